// File: rtl/drift_hist.sv
// drift_hist: baseline-drift histogrammer with saturating bins, rescale/pause on full.
// Optional DRIFT_HIST_PEAK_EN enables peak (mode) tracking and the baseline outputs.
module drift_hist #(
    parameter int ADC_W     = 14,
    parameter int BIN_BITS  = 5,
    parameter int CNT_W     = 20,
    parameter int MAX_COUNT = 2003
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADC_W-1:0]    adc,
    input  logic                adc_valid,
    input  logic [ADC_W-1:0]    center_val,
    input  logic                pause,
    input  logic                rescale_en,
    input  logic                read_fin,
    input  logic [BIN_BITS-1:0] rd_addr,
    output logic [CNT_W-1:0]    rd_data,
    output logic                filled,
    output logic                busy,
    output logic [ADC_W-1:0]    baseline,
    output logic                baseline_valid,
    output logic [1:0]          fsm_state
);

    localparam int NBINS = 2 ** BIN_BITS;
    localparam int HALF  = NBINS / 2 - 1;
    localparam int CW    = BIN_BITS + 1;

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_RESCALE = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       cnt;
    logic [ADC_W-1:0]    center_lat;
    logic [CNT_W-1:0]    mem [NBINS];

    logic                s1_v, s2_v;
    logic [BIN_BITS-1:0] s1_bin, s2_bin;
    logic [CNT_W-1:0]    s2_cnt, s2_new, s1_rd;
    logic [ADC_W+1:0]    bin_sum;
    logic [BIN_BITS-1:0] bin_s0, rs_addr;

    logic center_chg, full_hit, flush, accept, s2_we, last_rescale;
    logic                we;
    logic [BIN_BITS-1:0] waddr;
    logic [CNT_W-1:0]    wdata;

    // Clamp before truncation so far-out samples land in the end bins
    always_comb begin
        bin_sum = {2'b00, adc} - {2'b00, center_lat} + (ADC_W+2)'(HALF);
        if (bin_sum[ADC_W+1])
            bin_s0 = '0;
        else if (bin_sum > (ADC_W+2)'(NBINS-1))
            bin_s0 = '1;
        else
            bin_s0 = bin_sum[BIN_BITS-1:0];
    end

    assign s2_new       = (s2_cnt >= CNT_W'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : s2_cnt + 1'b1;
    assign s1_rd        = (s2_v && (s2_bin == s1_bin)) ? s2_new : mem[s1_bin];
    assign full_hit     = s2_v && (s2_cnt == CNT_W'(MAX_COUNT-1));
    assign center_chg   = (center_val != center_lat);
    assign last_rescale = (state == S_RESCALE) && (cnt == CW'(NBINS+1));
    assign accept       = (state == S_RUN) && adc_valid && !pause && !center_chg && !full_hit;
    assign flush        = (state_nx == S_INIT);
    assign s2_we        = s2_v && !flush;
    // First two rescale cycles drain the pipeline; modular subtract maps cnt 2..NBINS+1 to bins
    assign rs_addr      = cnt[BIN_BITS-1:0] - BIN_BITS'(2);

    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:    if (cnt == CW'(NBINS-1)) state_nx = S_RUN;
            S_RUN: begin
                if (center_chg)
                    state_nx = S_INIT;
                else if (full_hit)
                    state_nx = rescale_en ? S_RESCALE : S_PAUSE;
                else if (pause && !s1_v && !s2_v)
                    state_nx = S_PAUSE;
            end
            S_PAUSE: begin
                if (read_fin)
                    state_nx = S_INIT;
                else if (!pause && !filled)
                    state_nx = S_RUN;
            end
            S_RESCALE: if (last_rescale) state_nx = S_RUN;
            default:   state_nx = S_INIT;
        endcase
    end

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (state == S_INIT) begin
            we    = 1'b1;
            waddr = cnt[BIN_BITS-1:0];
        end else if (s2_we) begin
            we    = 1'b1;
            waddr = s2_bin;
            wdata = s2_new;
        end else if (state == S_RESCALE && cnt >= CW'(2)) begin
            we    = 1'b1;
            waddr = rs_addr;
            wdata = mem[rs_addr] >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            cnt        <= '0;
            center_lat <= '0;
            filled     <= 1'b0;
            rd_data    <= '0;
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
        end else begin
            state   <= state_nx;
            rd_data <= mem[rd_addr];
            s1_v    <= accept;
            s2_v    <= s1_v && !flush;
            if ((state == S_INIT || state == S_RESCALE) && state_nx == state)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (state == S_INIT && cnt == CW'(NBINS-1))
                center_lat <= center_val;
            if (state == S_INIT || last_rescale)
                filled <= 1'b0;
            else if (state == S_RUN && full_hit && !center_chg)
                filled <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        s1_bin <= bin_s0;
        s2_bin <= s1_bin;
        s2_cnt <= s1_rd;
    end

    assign busy      = (state == S_INIT) || (state == S_RESCALE);
    assign fsm_state = state;

`ifdef DRIFT_HIST_PEAK_EN
    logic [CNT_W-1:0]    peak_count;
    logic [BIN_BITS-1:0] peak_bin;
    logic [ADC_W+1:0]    bl_sum;

    always_ff @(posedge clk) begin
        if (rst || state == S_INIT) begin
            peak_count     <= '0;
            peak_bin       <= '0;
            baseline_valid <= 1'b0;
        end else begin
            if (s2_we && s2_new > peak_count) begin
                peak_count <= s2_new;
                peak_bin   <= s2_bin;
            end else if (last_rescale) begin
                peak_count <= peak_count >> 1;
            end
            if (s2_we)
                baseline_valid <= 1'b1;
        end
    end

    always_comb begin
        bl_sum = {2'b00, center_lat} + (ADC_W+2)'(peak_bin) - (ADC_W+2)'(HALF);
        if (bl_sum[ADC_W+1])
            baseline = '0;
        else if (bl_sum[ADC_W])
            baseline = '1;
        else
            baseline = bl_sum[ADC_W-1:0];
    end
`else
    assign baseline       = '0;
    assign baseline_valid = 1'b0;
`endif

endmodule

// File: tb/tb_drift_hist.sv
// Randomised and directed bench for drift_hist against a bin-count reference model.
module tb_drift_hist;

    localparam int ADC_W    = 14;
    localparam int BIN_BITS = 5;
    localparam int CNT_W    = 20;
    localparam int MAXC     = 2003;
    localparam int NB       = 32;
    localparam int HALF     = 15;
    localparam int ADC_MAX  = 16383;

    logic                clk = 1'b0;
    logic                rst;
    logic [ADC_W-1:0]    adc;
    logic                adc_valid;
    logic [ADC_W-1:0]    center_val;
    logic                pause;
    logic                rescale_en;
    logic                read_fin;
    logic [BIN_BITS-1:0] rd_addr;
    logic [CNT_W-1:0]    rd_data;
    logic                filled;
    logic                busy;
    logic [ADC_W-1:0]    baseline;
    logic                baseline_valid;
    logic [1:0]          fsm_state;

    drift_hist #(
        .ADC_W(ADC_W), .BIN_BITS(BIN_BITS), .CNT_W(CNT_W), .MAX_COUNT(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .adc(adc), .adc_valid(adc_valid),
        .center_val(center_val), .pause(pause), .rescale_en(rescale_en),
        .read_fin(read_fin), .rd_addr(rd_addr), .rd_data(rd_data),
        .filled(filled), .busy(busy), .baseline(baseline),
        .baseline_valid(baseline_valid), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int m_bins [NB];
    int m_center, m_pk_cnt, m_pk_bin;
    bit m_any;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int bin_of(input int a, input int c);
        int b;
        b = a - c + HALF;
        if (b < 0) b = 0;
        if (b > NB - 1) b = NB - 1;
        return b;
    endfunction

    task automatic m_clear(input int c);
        foreach (m_bins[i]) m_bins[i] = 0;
        m_center = c;
        m_pk_cnt = 0;
        m_pk_bin = 0;
        m_any    = 0;
    endtask

    task automatic m_add(input int a);
        int b;
        b = bin_of(a, m_center);
        if (m_bins[b] < MAXC) m_bins[b]++;
        if (m_bins[b] > m_pk_cnt) begin
            m_pk_cnt = m_bins[b];
            m_pk_bin = b;
        end
        m_any = 1;
    endtask

    task automatic m_halve();
        foreach (m_bins[i]) m_bins[i] = m_bins[i] / 2;
        m_pk_cnt = m_pk_cnt / 2;
    endtask

    task automatic send(input int a);
        adc       = ADC_W'(a);
        adc_valid = 1'b1;
        step();
        adc_valid = 1'b0;
        m_add(a);
    endtask

    task automatic wait_state(input int s, input int lim, input string tag);
        int n;
        n = 0;
        while (int'(fsm_state) != s && n < lim) begin
            step();
            n++;
        end
        check(tag, int'(fsm_state), s);
    endtask

    task automatic do_pause(input string tag);
        adc_valid = 1'b0;
        pause     = 1'b1;
        wait_state(2, 10, {tag, "_to_pause"});
    endtask

    task automatic unpause(input string tag);
        pause = 1'b0;
        wait_state(1, 5, {tag, "_to_run"});
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < NB; i++) begin
            rd_addr = BIN_BITS'(i);
            step();
            check($sformatf("%s_bin%0d", tag, i), int'(rd_data), m_bins[i]);
        end
    endtask

    task automatic check_baseline(input string tag);
        int e;
        e = m_center + m_pk_bin - HALF;
        if (e < 0) e = 0;
        if (e > ADC_MAX) e = ADC_MAX;
`ifdef DRIFT_HIST_PEAK_EN
        check({tag, "_baseline"}, int'(baseline), e);
        check({tag, "_bl_valid"}, int'(baseline_valid), int'(m_any));
`else
        check({tag, "_baseline"}, int'(baseline), 0);
        check({tag, "_bl_valid"}, int'(baseline_valid), 0);
`endif
    endtask

    // From PAUSE: request readout-complete, expect INIT, then RUN with cleared bins
    task automatic restart(input int c, input string tag);
        center_val = ADC_W'(c);
        pause      = 1'b0;
        read_fin   = 1'b1;
        step();
        read_fin   = 1'b0;
        check({tag, "_init_state"}, int'(fsm_state), 0);
        check({tag, "_init_busy"}, int'(busy), 1);
        wait_state(1, 40, {tag, "_init_done"});
        check({tag, "_filled_clr"}, int'(filled), 0);
        m_clear(c);
    endtask

    task automatic run_random(input int c, input string tag);
        int a;
        restart(c, tag);
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 9) < 7) begin
                a = c + int'($urandom_range(0, 50)) - 25;
                if ($urandom_range(0, 19) == 0) a = ($urandom_range(0, 1) == 1) ? ADC_MAX : 0;
                if (a < 0) a = 0;
                if (a > ADC_MAX) a = ADC_MAX;
                adc       = ADC_W'(a);
                adc_valid = 1'b1;
                m_add(a);
            end else begin
                adc_valid = 1'b0;
            end
            step();
        end
        adc_valid = 1'b0;
        do_pause(tag);
        read_all(tag);
        check_baseline(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        adc        = '0;
        adc_valid  = 1'b0;
        center_val = ADC_W'(1000);
        pause      = 1'b0;
        rescale_en = 1'b0;
        read_fin   = 1'b0;
        rd_addr    = '0;
        m_clear(1000);
        repeat (3) step();
        check("rst_state", int'(fsm_state), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_filled", int'(filled), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_baseline", int'(baseline), 0);
        check("rst_bl_valid", int'(baseline_valid), 0);
        rst = 1'b0;

        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check("init_busy_cycles", n, NB);
        check("init_to_run", int'(fsm_state), 1);
        do_pause("reset");
        read_all("reset");
        unpause("reset");

        send(1005);
        do_pause("single");
        read_all("single");
        check_baseline("single");
        unpause("single");

        repeat (5) send(990);
        send(991);
        send(990);
        send(991);
        do_pause("fwd");
        read_all("fwd");
        check_baseline("fwd");
        unpause("fwd");

        send(0);
        send(ADC_MAX);
        do_pause("ends");
        read_all("ends");

        run_random(3, "rnd_lo");
        run_random(16380, "rnd_hi");
        run_random(int'($urandom_range(0, ADC_MAX)), "rnd_mid");

        // Saturating fill with rescale disabled
        restart(1000, "fill");
        repeat (MAXC + 2) send(1000);
        wait_state(2, 10, "fill_pause");
        check("fill_filled", int'(filled), 1);
        read_all("fill");
        check_baseline("fill");
        restart(1000, "fill_clr");
        read_all("fill_clr");

        // Rescale on full
        rescale_en = 1'b1;
        repeat (7) send(988);
        repeat (MAXC - 1) send(1000);
        send(1000);
        n = 0;
        while (!busy && n < 10) begin
            n++;
            step();
        end
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check("rescale_cycles", n, NB + 2);
        check("rescale_state", int'(fsm_state), 1);
        check("rescale_filled", int'(filled), 0);
        m_halve();
        do_pause("rescale");
        read_all("rescale");
        check_baseline("rescale");
        unpause("rescale");

        center_val = ADC_W'(1200);
        step();
        check("center_chg_init", int'(fsm_state), 0);
        wait_state(1, 40, "center_chg_run");
        m_clear(1200);
        send(1200);
        send(1185);
        do_pause("newc");
        read_all("newc");
        check_baseline("newc");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
